// File: rtl/ingress_pkt_buffer.sv
// ingress_pkt_buffer: per-port store-and-forward buffer feeding the switch core.
// Optional INGRESS_STATS_EN adds saturating forward/drop counters.
module ingress_pkt_buffer #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  output logic        out_req,
  output logic [1:0]  out_dest,
  input  logic        out_grant,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop
`ifdef INGRESS_STATS_EN
  ,
  output logic [15:0] stat_fwd,
  output logic [15:0] stat_drop
`endif
);

  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic {
    RD_IDLE,
    RD_SEND
  } rd_state_e;

  logic [9:0]    mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          open_q, open_d;
  logic          discard_q, discard_d;
  rd_state_e     state_q, state_d;

  logic          out_valid_q, out_valid_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;
  logic [7:0]    out_data_q, out_data_d;

  logic          full;
  logic          oversize;
  logic          accept;
  logic          we;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wbase;
  logic          pkt_in;
  logic          pkt_out;
  logic          emit;
  logic          grant_take;
  logic [9:0]    rd_word;

  assign full     = (wr_ptr_q - rd_ptr_q) == FULL_CNT;
  assign oversize = full && open_q && (pkt_cnt_q == '0);

  // An oversize packet keeps in_ready high so the rest of it drains away
  assign in_ready = !full || discard_q || oversize;
  assign accept   = in_valid && in_ready;

  // A sop always lands at commit_ptr, dropping any open partial packet
  assign wbase    = in_sop ? commit_ptr_q : wr_ptr_q;

  assign rd_word  = mem_q[rd_ptr_q[AW-1:0]];

  // Held off for the out_eop cycle so back-to-back requests show a gap
  assign out_req    = (state_q == RD_IDLE) && (pkt_cnt_q != '0)
                      && !out_eop_q;
  assign out_dest   = out_req ? rd_word[1:0] : 2'b00;
  assign grant_take = out_req && out_grant;

  assign out_valid  = out_valid_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign out_data   = out_data_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    open_d       = open_q;
    discard_d    = discard_q;
    we           = 1'b0;
    waddr        = wr_ptr_q[AW-1:0];
    pkt_in       = 1'b0;
    if (oversize) begin
      wr_ptr_d  = commit_ptr_q;
      open_d    = 1'b0;
      discard_d = !(in_valid && in_eop);
    end else if (discard_q) begin
      if (in_valid && in_eop) begin
        discard_d = 1'b0;
      end
    end else if (accept && (in_sop || open_q)) begin
      we       = 1'b1;
      waddr    = wbase[AW-1:0];
      wr_ptr_d = wbase + PTR_ONE;
      open_d   = !in_eop;
      if (in_eop) begin
        commit_ptr_d = wbase + PTR_ONE;
        pkt_in       = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_out     = 1'b0;
    emit        = 1'b0;
    out_valid_d = 1'b0;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    out_data_d  = 8'h00;
    unique case (state_q)
      RD_IDLE: emit = grant_take;
      RD_SEND: emit = 1'b1;
      default: emit = 1'b0;
    endcase
    if (emit) begin
      out_valid_d = 1'b1;
      out_sop_d   = rd_word[9];
      out_eop_d   = rd_word[8];
      out_data_d  = rd_word[7:0];
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      pkt_out     = rd_word[8];
      state_d     = rd_word[8] ? RD_IDLE : RD_SEND;
    end
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_in && !pkt_out) begin
      pkt_cnt_d = pkt_cnt_q + PTR_ONE;
    end else if (pkt_out && !pkt_in) begin
      pkt_cnt_d = pkt_cnt_q - PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= {in_sop, in_eop, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      open_q       <= 1'b0;
      discard_q    <= 1'b0;
      state_q      <= RD_IDLE;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_data_q   <= 8'h00;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      open_q       <= open_d;
      discard_q    <= discard_d;
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_data_q   <= out_data_d;
    end
  end

`ifdef INGRESS_STATS_EN
  logic [15:0] stat_fwd_q, stat_fwd_d;
  logic [15:0] stat_drop_q, stat_drop_d;
  logic        drop_evt;

  assign drop_evt = oversize
                    || (!discard_q && accept && in_sop && open_q);

  always_comb begin
    stat_fwd_d  = stat_fwd_q;
    stat_drop_d = stat_drop_q;
    if (pkt_out && (stat_fwd_q != 16'hFFFF)) begin
      stat_fwd_d = stat_fwd_q + 16'd1;
    end
    if (drop_evt && (stat_drop_q != 16'hFFFF)) begin
      stat_drop_d = stat_drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fwd_q  <= 16'h0000;
      stat_drop_q <= 16'h0000;
    end else begin
      stat_fwd_q  <= stat_fwd_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_fwd  = stat_fwd_q;
  assign stat_drop = stat_drop_q;
`endif

endmodule
